ecc_scrub_ctrl: RTL and testbench
=================================

Name: ecc_scrub_ctrl

Overview:
- Background memory scrubber that sequences the 32-bit single-error-correcting corrector datapath (32 data in, 8 check bits in, correction enable, 32 corrected data out).
- Walks every word of a memory: reads the word, presents data and check bits to the corrector, and writes back the corrected word if the corrector changed any data bit.
- Counts corrections and reports pass completion.
- Sits between the memory arbiter (as a low-priority requester) and the combinational corrector instance.

Parameters:
- ADDR_W, 8, memory address width; the scrub covers addresses 0 .. 2^ADDR_W-1.
- INTERVAL, 1024, idle cycles between consecutive word scrubs; legal range 1 .. 65535.
- CNT_W, 16, width of the correction counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  scrub enable; level-sensitive
- clr_cnt  in  1  single-cycle pulse; clears err_cnt
- mem_req  out  1  memory access request; held until granted
- mem_gnt  in  1  arbiter grant; the access transfers in the cycle where mem_req and mem_gnt are both 1
- mem_we  out  1  1 = write, 0 = read; valid while mem_req = 1
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  32  write data
- mem_wcheck  out  8  write check bits
- mem_rvalid  in  1  read data valid; arrives at least 1 cycle after a read grant
- mem_rdata  in  32  read data
- mem_rcheck  in  8  read check bits
- cor_din  out  32  to corrector data inputs
- cor_cin  out  8  to corrector check-bit inputs
- cor_en  out  1  to corrector enable
- cor_dout  in  32  corrected data from corrector (combinational)
- corrected  out  1  1-cycle pulse when a write-back is scheduled
- pass_done  out  1  1-cycle pulse when the last address finishes
- err_cnt  out  CNT_W  saturating count of corrected words
- busy  out  1  1 in every state except IDLE and WAIT

Behaviour:
- Reset values:
  - All outputs are 0.
  - The address pointer, the interval counter and err_cnt are 0.
  - The FSM is in IDLE.
- IDLE:
  - If en = 1, load the interval counter with INTERVAL-1 and go to WAIT.
- WAIT:
  - Decrement the interval counter each cycle.
  - At 0, go to RD_REQ.
  - If en = 0, return to IDLE.
- RD_REQ:
  - Drive mem_req = 1, mem_we = 0, mem_addr = pointer.
  - When mem_gnt = 1, go to RD_WAIT.
  - en is ignored from RD_REQ through NEXT; a word that has started is always completed.
- RD_WAIT:
  - On mem_rvalid = 1, register mem_rdata and mem_rcheck into the held word, then go to CHECK.
- CHECK (exactly 1 cycle):
  - cor_en = 1, cor_din = held data, cor_cin = held check bits.
  - If cor_dout differs from the held data:
    - Register cor_dout as the write data.
    - Pulse corrected.
    - Increment err_cnt, saturating at 2^CNT_W-1.
    - Go to WR_REQ.
  - Otherwise, go to NEXT.
- WR_REQ:
  - Drive mem_req = 1, mem_we = 1, mem_addr = pointer, mem_wdata = corrected data, mem_wcheck = held check bits.
  - When mem_gnt = 1, go to NEXT.
- NEXT:
  - Increment the pointer.
  - If the pointer was 2^ADDR_W-1, it wraps to 0 and pass_done pulses.
  - If en = 1, reload the interval counter and go to WAIT; otherwise go to IDLE.
- cor_en is 0 outside CHECK. cor_din and cor_cin hold the held word at all times, so the corrector input is stable.
- Fastest clean-word cycle (immediate grant, rvalid 1 cycle after grant): INTERVAL + 4 cycles per word.
- mem_req, mem_we, mem_addr, mem_wdata and mem_wcheck must stay stable while mem_req = 1 and mem_gnt = 0.
- clr_cnt:
  - Sets err_cnt to 0.
  - If clr_cnt coincides with an increment, the result is 0 (clear wins).
- Check-bit-only errors (cor_dout equals held data) cause no write-back and no count.
- Asynchronous reset mid-access:
  - Immediately drops mem_req and returns every register to its reset value.
  - Memory side effects already granted are not undone.
- A mem_rvalid that arrives outside RD_WAIT is ignored.

Test Plan:
- Clean word: en = 1, INTERVAL = 4, mem_gnt tied 1, rvalid 1 cycle after grant, memory holds 0x12345678 with matching check bits → read at address 0, cor_en high for 1 cycle, no write, err_cnt = 0, next read at address 1 exactly 8 cycles after the first read grant.
- Single-bit data error: word 0x12345678 stored with bit 5 flipped (0x12345658) → corrected pulses, one write to the same address with data 0x12345678 and the original check bits, err_cnt = 1.
- Grant stall: mem_gnt held 0 for 10 cycles during the write → mem_req, mem_addr and mem_wdata are stable for all 10 cycles; the write completes on the first grant cycle.
- Full pass: ADDR_W = 3, all words clean → 8 reads at addresses 0..7, pass_done pulses once after address 7, the next read is at address 0.
- Enable drop and counter controls:
  - en dropped during RD_WAIT → the current word finishes (including its write if needed), then the FSM goes to IDLE and busy = 0.
  - clr_cnt pulsed in the same cycle as a correction → err_cnt = 0.
  - CNT_W = 2 with 5 corrections → err_cnt saturates at 3.
- Reset mid-write: rst asserted while in WR_REQ with mem_gnt = 0 → mem_req is 0 immediately (asynchronously), the pointer returns to 0, err_cnt = 0; after rst deasserts with en = 1, the scrub restarts at address 0.

Source files
------------

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: background scrubber that reads each word, runs it through the
// SEC corrector and writes back words whose data bits were corrected.
module ecc_scrub_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int INTERVAL = 1024,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_cnt,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [7:0]        mem_wcheck,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic [7:0]        mem_rcheck,
  output logic [31:0]       cor_din,
  output logic [7:0]        cor_cin,
  output logic              cor_en,
  input  logic [31:0]       cor_dout,
  output logic              corrected,
  output logic              pass_done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, WAIT, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT} state_t;
  localparam logic [15:0] IVL_LOAD = 16'(INTERVAL - 1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       ivl_q, ivl_d;
  logic [31:0]       data_q, data_d, wdata_q, wdata_d;
  logic [7:0]        chk_q, chk_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ivl_d     = ivl_q;
    data_d    = data_q;
    chk_d     = chk_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    corrected = 1'b0;
    pass_done = 1'b0;
    case (state_q)
      IDLE: if (en) begin
        ivl_d   = IVL_LOAD;
        state_d = WAIT;
      end
      WAIT: if (!en) state_d = IDLE;
        else if (ivl_q == 16'd0) state_d = RD_REQ;
        else ivl_d = ivl_q - 16'd1;
      RD_REQ: if (mem_gnt) state_d = RD_WAIT;
      RD_WAIT: if (mem_rvalid) begin
        data_d  = mem_rdata;
        chk_d   = mem_rcheck;
        state_d = CHECK;
      end
      CHECK: if (cor_dout != data_q) begin
        wdata_d   = cor_dout;
        corrected = 1'b1;
        cnt_d     = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
        state_d   = WR_REQ;
      end else state_d = NEXT;
      WR_REQ: if (mem_gnt) state_d = NEXT;
      NEXT: begin
        ptr_d     = ptr_q + ADDR_W'(1);
        pass_done = &ptr_q;
        ivl_d     = en ? IVL_LOAD : ivl_q;
        state_d   = en ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // clear takes priority over a same-cycle correction
    cnt_d = clr_cnt ? '0 : cnt_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ivl_q   <= '0;
      data_q  <= '0;
      chk_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ivl_q   <= ivl_d;
      data_q  <= data_d;
      chk_q   <= chk_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end
  assign mem_req    = state_q == RD_REQ || state_q == WR_REQ;
  assign mem_we     = state_q == WR_REQ;
  assign mem_addr   = ptr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wcheck = chk_q;
  assign cor_din    = data_q;
  assign cor_cin    = chk_q;
  assign cor_en     = state_q == CHECK;
  assign err_cnt    = cnt_q;
  assign busy       = !(state_q == IDLE || state_q == WAIT);
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl: scoreboard bench with a memory model and a Hamming SEC corrector model.
module tb_ecc_scrub_ctrl;
  localparam int AW = 3, IV = 4, CW = 2;
  localparam logic [31:0] ORIG [8] = '{32'h12345678, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF,
                                       32'h0F0F0F0F, 32'h80000001, 32'hCAFEF00D, 32'h13579BDF};
  localparam int FLIP [8] = '{5, 0, 31, 16, 7, 12, 3, 20};
  logic clk = 0, rst = 1, en = 0, clr_manual = 0, clr_arm = 0, mem_gnt = 1, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0, cor_dout, mem_wdata, cor_din, rd_d = 0;
  logic [7:0] mem_rcheck = 0, mem_wcheck, cor_cin, rd_c = 0;
  logic mem_req, mem_we, cor_en, corrected, pass_done, busy, clr_cnt;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] err_cnt;
  logic [31:0] mem_d [8] = ORIG;
  logic [31:0] flip_m [8] = '{default: 0};
  int stall_len [8] = '{default: 0};
  int checks = 0, errors = 0, cyc = 0, last_cyc = 0, n_acc = 0, n_cor = 0, n_corr = 0, n_pass = 0, st_cnt = 0;
  logic [AW-1:0] last_addr = 0, s_addr = 0;
  logic [31:0] s_d = 0;
  logic [7:0] s_c = 0;
  logic was_stalled = 0;
  typedef struct { logic we; logic [AW-1:0] addr; int gap; int cnt; } acc_t;
  acc_t exp_q [$];

  ecc_scrub_ctrl #(.ADDR_W(AW), .INTERVAL(IV), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wcheck(mem_wcheck),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rcheck(mem_rcheck), .cor_din(cor_din),
    .cor_cin(cor_cin), .cor_en(cor_en), .cor_dout(cor_dout), .corrected(corrected),
    .pass_done(pass_done), .err_cnt(err_cnt), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [5:0] pos(input int i);
    int n = 0;
    logic [5:0] r = 0;
    for (int p = 3; p < 64; p++) if ((p & (p - 1)) != 0) begin
      if (n == i) r = 6'(p);
      n++;
    end
    return r;
  endfunction
  function automatic logic [7:0] enc(input logic [31:0] d);
    logic [5:0] s = 0;
    for (int i = 0; i < 32; i++) if (d[i]) s ^= pos(i);
    return {2'b00, s};
  endfunction
  function automatic logic [31:0] fix(input logic [31:0] d, input logic [7:0] c);
    logic [5:0] s = enc(d)[5:0] ^ c[5:0];
    logic [31:0] r = d;
    for (int i = 0; i < 32; i++) if (s != 0 && pos(i) == s) r[i] = ~r[i];
    return r;
  endfunction

  always_comb cor_dout = cor_en ? fix(cor_din, cor_cin) : cor_din;
  assign clr_cnt = clr_manual | (clr_arm & corrected & (mem_addr == 3'd6));

  // memory: stored words are clean; flip_m injects data faults on read
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (mem_req && mem_gnt) begin
      if (mem_we) mem_d[mem_addr] <= mem_wdata;
      else begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem_d[mem_addr] ^ flip_m[mem_addr];
        mem_rcheck <= enc(mem_d[mem_addr]);
        rd_d       <= mem_d[mem_addr] ^ flip_m[mem_addr];
        rd_c       <= enc(mem_d[mem_addr]);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (mem_req && mem_we && st_cnt < stall_len[mem_addr]) begin
      mem_gnt = 1'b0;
      st_cnt++;
    end else begin
      mem_gnt = 1'b1;
      st_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (mem_req && mem_gnt) begin
      acc_t e;
      n_acc++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_access we=%0b addr=%0d", mem_we, mem_addr);
      end else begin
        e = exp_q.pop_front();
        if (mem_we !== e.we || mem_addr !== e.addr || int'(err_cnt) != e.cnt ||
            (e.we && (mem_wdata !== ORIG[e.addr] || mem_wcheck !== enc(ORIG[e.addr]))) ||
            (e.gap != 0 && cyc - last_cyc != e.gap)) begin
          errors++;
          $display("FAIL access%0d got we=%0b addr=%0d wd=%h wc=%h cnt=%0d gap=%0d exp we=%0b addr=%0d wd=%h wc=%h cnt=%0d gap=%0d",
                   n_acc, mem_we, mem_addr, mem_wdata, mem_wcheck, err_cnt, cyc - last_cyc,
                   e.we, e.addr, ORIG[e.addr], enc(ORIG[e.addr]), e.cnt, e.gap);
        end
      end
      last_cyc = cyc;
      last_addr = mem_addr;
    end
    if (mem_req && !mem_gnt) begin
      if (was_stalled) begin
        checks++;
        if (mem_addr !== s_addr || mem_wdata !== s_d || mem_wcheck !== s_c || !mem_we) begin
          errors++;
          $display("FAIL stall_stable got addr=%0d wd=%h wc=%h exp addr=%0d wd=%h wc=%h",
                   mem_addr, mem_wdata, mem_wcheck, s_addr, s_d, s_c);
        end
      end
      s_addr = mem_addr;
      s_d = mem_wdata;
      s_c = mem_wcheck;
    end
    was_stalled = mem_req && !mem_gnt;
    if (cor_en) begin
      n_cor++;
      checks++;
      if (cor_din !== rd_d || cor_cin !== rd_c) begin
        errors++;
        $display("FAIL cor_in got %h/%h exp %h/%h", cor_din, cor_cin, rd_d, rd_c);
      end
    end
    if (corrected) n_corr++;
    if (pass_done) begin
      n_pass++;
      checks++;
      if (last_addr !== 3'd7) begin
        errors++;
        $display("FAIL pass_done_addr got %0d exp 7", last_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic push(input logic we, input int a, input int gap, input int cnt);
    acc_t e;
    e.we = we; e.addr = AW'(a); e.gap = gap; e.cnt = cnt;
    exp_q.push_back(e);
  endtask
  task automatic wait_acc(input int n);
    int t = 0;
    while (n_acc < n && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (n_acc < n) chk("access_timeout", 64'(n_acc), 64'(n));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ctl", {mem_req, mem_we, cor_en, corrected, pass_done, busy}, 0);
    chk("rst_addr_cnt", {mem_addr, err_cnt}, 0);
    chk("rst_wdata", {mem_wdata, mem_wcheck}, 0);
    chk("rst_cor", {cor_din, cor_cin}, 0);
    rst = 0;
    for (int a = 0; a < 8; a++) push(0, a, a == 0 ? 0 : 8, 0);
    push(0, 0, 8, 0);
    push(1, 0, 3, 1);
    en = 1;
    wait_acc(2);
    flip_m[0] = 32'(1) << FLIP[0];
    wait_acc(9);
    @(posedge clk);
    #1;
    en = 0;
    chk("busy_rd_wait", 64'(busy), 1);
    wait_acc(10);
    repeat (6) @(negedge clk);
    chk("idle_after_drop", {busy, mem_req}, 0);
    chk("ptr_after_drop", 64'(mem_addr), 1);
    chk("err_cnt_one", 64'(err_cnt), 1);
    chk("pass_once", 64'(n_pass), 1);
    clr_manual = 1;
    @(negedge clk);
    clr_manual = 0;
    chk("clr_idle", 64'(err_cnt), 0);
    flip_m[0] = 0;
    for (int a = 1; a < 8; a++) flip_m[a] = 32'(1) << FLIP[a];
    stall_len[1] = 10;
    stall_len[7] = 1000;
    clr_arm = 1;
    push(0, 1, 0, 0); push(1, 1, 13, 1);
    push(0, 2, 6, 1); push(1, 2, 3, 2);
    push(0, 3, 6, 2); push(1, 3, 3, 3);
    push(0, 4, 6, 3); push(1, 4, 3, 3);
    push(0, 5, 6, 3); push(1, 5, 3, 3);
    push(0, 6, 6, 3); push(1, 6, 3, 0);
    push(0, 7, 6, 0);
    en = 1;
    wait_acc(23);
    repeat (5) @(negedge clk);
    chk("wr7_stalled", {mem_req, mem_we, mem_gnt}, 3'b110);
    chk("err_cnt_w7", 64'(err_cnt), 1);
    #2 rst = 1;
    #1;
    chk("rst_async_req", {mem_req, busy}, 0);
    chk("rst_async_regs", {mem_addr, err_cnt}, 0);
    stall_len[7] = 0;
    clr_arm = 0;
    push(0, 0, 0, 0);
    @(negedge clk);
    rst = 0;
    wait_acc(24);
    @(posedge clk);
    #1;
    en = 0;
    repeat (10) @(negedge clk);
    chk("final_idle", {busy, mem_req}, 0);
    chk("cor_en_pulses", 64'(n_cor), 17);
    chk("corrected_pulses", 64'(n_corr), 8);
    chk("pass_total", 64'(n_pass), 1);
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
